// File: rtl/seq_latch_array.sv
// Bank of independent clocked NOR-latch models (SR, D enable-high, D enable-low)
// with a per-channel settle filter, forbidden-state tracking and sticky error flags.
module seq_latch_array #(
  parameter int CHANNELS = 4,
  parameter int SETTLE   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   a,
  input  logic [CHANNELS-1:0]   b,
  input  logic                  err_clr,
  output logic [CHANNELS-1:0]   q,
  output logic [CHANNELS-1:0]   p,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   forbid_err,
  output logic [CHANNELS-1:0]   race_err
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);

  typedef enum logic [1:0] {REQ_HOLD, REQ_SET, REQ_RESET, REQ_FORBID} req_e;
  typedef enum logic [1:0] {ST_STABLE, ST_PENDING, ST_FORBID} state_e;

  req_e              last_req_q [CHANNELS];
  req_e              last_req_d [CHANNELS];
  req_e              comm_q     [CHANNELS];
  req_e              comm_d     [CHANNELS];
  state_e            state_q    [CHANNELS];
  state_e            state_d    [CHANNELS];
  logic [CW-1:0]     cnt_q      [CHANNELS];
  logic [CW-1:0]     cnt_d      [CHANNELS];
  logic [CHANNELS-1:0] q_mem_q, q_mem_d, q_q, q_d, p_q, p_d;
  logic [CHANNELS-1:0] forbid_q, forbid_d, race_q, race_d;

  function automatic req_e decode(input logic [1:0] m, input logic ai, input logic bi);
    req_e r;
    r = REQ_HOLD;
    case (m)
      2'b00:   r = ({ai, bi} == 2'b10) ? REQ_SET :
                   ({ai, bi} == 2'b01) ? REQ_RESET :
                   ({ai, bi} == 2'b11) ? REQ_FORBID : REQ_HOLD;
      2'b01:   r = bi  ? (ai ? REQ_SET : REQ_RESET) : REQ_HOLD;
      2'b10:   r = !bi ? (ai ? REQ_SET : REQ_RESET) : REQ_HOLD;
      default: r = REQ_HOLD;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        last_req_q[c] <= REQ_HOLD;
        comm_q[c]     <= REQ_HOLD;
        state_q[c]    <= ST_STABLE;
        cnt_q[c]      <= CNT_MAX;
      end
      q_mem_q  <= '0;
      q_q      <= '0;
      p_q      <= '1;
      forbid_q <= '0;
      race_q   <= '0;
    end else begin
      last_req_q <= last_req_d;
      comm_q     <= comm_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_mem_q    <= q_mem_d;
      q_q        <= q_d;
      p_q        <= p_d;
      forbid_q   <= forbid_d;
      race_q     <= race_d;
    end
  end

  always_comb begin
    last_req_d = last_req_q;
    comm_d     = comm_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_mem_d    = q_mem_q;
    q_d        = q_q;
    p_d        = p_q;
    forbid_d   = forbid_q & ~{CHANNELS{err_clr}};
    race_d     = race_q & ~{CHANNELS{err_clr}};
    for (int c = 0; c < CHANNELS; c++) begin
      req_e req_c;
      req_c = decode(mode[2*c +: 2], a[c], b[c]);
      if (req_c != last_req_q[c]) begin
        last_req_d[c] = req_c;
        cnt_d[c]      = CW'(1);
      end else if (cnt_q[c] != CNT_MAX) begin
        cnt_d[c] = cnt_q[c] + CW'(1);
      end
      // Commit on the SETTLE-th consecutive sample; a saturated count re-commits idempotently.
      if (cnt_d[c] == CNT_MAX) begin
        comm_d[c] = last_req_d[c];
        case (last_req_d[c])
          REQ_SET:    begin q_d[c] = 1'b1; p_d[c] = 1'b0; q_mem_d[c] = 1'b1; end
          REQ_RESET:  begin q_d[c] = 1'b0; p_d[c] = 1'b1; q_mem_d[c] = 1'b0; end
          REQ_FORBID: begin q_d[c] = 1'b0; p_d[c] = 1'b0; forbid_d[c] = 1'b1; end
          default: begin
            if (comm_q[c] == REQ_FORBID) begin
              q_d[c] = q_mem_q[c];
              p_d[c] = ~q_mem_q[c];
            end
          end
        endcase
        if (comm_q[c] == REQ_FORBID && last_req_d[c] != REQ_FORBID)
          race_d[c] = 1'b1;
      end
      if (cnt_d[c] < CNT_MAX && last_req_d[c] != comm_d[c])
        state_d[c] = ST_PENDING;
      else if (comm_d[c] == REQ_FORBID)
        state_d[c] = ST_FORBID;
      else
        state_d[c] = ST_STABLE;
    end
  end

  always_comb begin
    busy = '0;
    for (int c = 0; c < CHANNELS; c++)
      busy[c] = (state_q[c] == ST_PENDING);
  end

  assign q          = q_q;
  assign p          = p_q;
  assign forbid_err = forbid_q;
  assign race_err   = race_q;

endmodule
